// File: rtl/gus16_pkg.sv
// Shared definitions for the gus16 accumulator ALU: opcode encoding,
// flag bit positions within uio_out, and the bidir output-enable mask.
// Latency: n/a (package). Backpressure: n/a.
package gus16_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,   // becomes MUL when GUS16_MUL_EN is defined
    OP_LDBL = 4'd1,
    OP_LDBH = 4'd2,
    OP_MOVA = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_INC  = 4'd11,
    OP_DEC  = 4'd12,
    OP_SELL = 4'd13,
    OP_SELH = 4'd14,
    OP_CLR  = 4'd15
  } op_t;

  localparam int FLG_Z = 7;
  localparam int FLG_N = 6;
  localparam int FLG_C = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'hE0;

endpackage

// File: rtl/gus16_alu.sv
// Combinational datapath of gus16: computes the new accumulator value and carry.
// Latency: 0 cycles (purely combinational). Backpressure: none.
// Ports: op (opcode), a/b (accumulator, operand), c_in (current carry) ->
//        result, c_out, writes_a (op updates A, Z, N), writes_c (op updates C).
// Option: GUS16_MUL_EN turns opcode 0 into an 8x8->16 multiply.
module gus16_alu
  import gus16_pkg::*;
(
  input  op_t         op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] result,
  output logic        c_out,
  output logic        writes_a,
  output logic        writes_c
);

  // 17-bit sum so the carry out of ADD falls out of the top bit.
  logic [16:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result   = a;
    c_out    = c_in;
    writes_a = 1'b0;
    writes_c = 1'b0;
    case (op)
`ifdef GUS16_MUL_EN
      OP_NOP: begin
        result   = 16'(a[7:0]) * 16'(b[7:0]);
        c_out    = 1'b0;
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
`endif
      OP_MOVA: begin
        // MOVA updates Z/N but deliberately keeps C.
        result   = b;
        writes_a = 1'b1;
      end
      OP_ADD: begin
        result   = sum[15:0];
        c_out    = sum[16];
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_SUB: begin
        result   = a - b;
        c_out    = (a < b);
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_AND: begin
        result   = a & b;
        c_out    = 1'b0;
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_OR: begin
        result   = a | b;
        c_out    = 1'b0;
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_XOR: begin
        result   = a ^ b;
        c_out    = 1'b0;
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_SHL: begin
        result   = {a[14:0], 1'b0};
        c_out    = a[15];
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_SHR: begin
        result   = {1'b0, a[15:1]};
        c_out    = a[0];
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_INC: begin
        result   = a + 16'd1;
        c_out    = (a == 16'hFFFF);
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      OP_DEC: begin
        result   = a - 16'd1;
        c_out    = (a == 16'h0000);
        writes_a = 1'b1;
        writes_c = 1'b1;
      end
      default: ;  // LDBL/LDBH/SELL/SELH/CLR are handled in the top
    endcase
  end

endmodule

// File: rtl/gus16.sv
// gus16: 16-bit accumulator ALU on the TinyTapeout 8/8/8 pad harness.
// Latency: command executes on the strobe rising edge; results visible the next cycle.
// Backpressure: none; one command per strobe rising edge, ena=0 holds all state.
// Ports: clk, rst_n (async active-low), ena, ui_in (operand byte),
//        uo_out (selected byte of A), uio_in ([3:0] opcode, [4] strobe),
//        uio_out ([7]=Z [6]=N [5]=C), uio_oe (constant E0).
// Option: GUS16_MUL_EN enables MUL on opcode 0 (otherwise NOP).
module gus16
  import gus16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        z_q;
  logic        n_q;
  logic        c_q;
  logic        sel_q;
  logic        strobe_q;

  op_t         op;
  logic        exec;
  logic [15:0] alu_result;
  logic        alu_c;
  logic        alu_writes_a;
  logic        alu_writes_c;

  assign op   = op_t'(uio_in[3:0]);
  // Rising-edge detect: a strobe held high executes only once.
  assign exec = ena & uio_in[4] & ~strobe_q;

  gus16_alu u_alu (
    .op       (op),
    .a        (a_q),
    .b        (b_q),
    .c_in     (c_q),
    .result   (alu_result),
    .c_out    (alu_c),
    .writes_a (alu_writes_a),
    .writes_c (alu_writes_c)
  );

  // Edge history tracks the pin even while deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe_q <= 1'b0;
    else        strobe_q <= uio_in[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      sel_q <= 1'b0;
    end else if (exec) begin
      case (op)
        OP_LDBL: b_q[7:0]  <= ui_in;
        OP_LDBH: b_q[15:8] <= ui_in;
        OP_SELL: sel_q     <= 1'b0;
        OP_SELH: sel_q     <= 1'b1;
        OP_CLR: begin
          // Clears everything, so Z ends up 0 even though A is 0.
          a_q   <= '0;
          b_q   <= '0;
          z_q   <= 1'b0;
          n_q   <= 1'b0;
          c_q   <= 1'b0;
          sel_q <= 1'b0;
        end
        default: begin
          if (alu_writes_a) begin
            a_q <= alu_result;
            z_q <= (alu_result == 16'h0000);
            n_q <= alu_result[15];
          end
          if (alu_writes_c) c_q <= alu_c;
        end
      endcase
    end
  end

  assign uo_out  = sel_q ? a_q[15:8] : a_q[7:0];

  always_comb begin
    uio_out        = 8'h00;
    uio_out[FLG_Z] = z_q;
    uio_out[FLG_N] = n_q;
    uio_out[FLG_C] = c_q;
  end

  assign uio_oe = UIO_OE_MASK;

  // uio_in[7:5] are inputs by pad assignment but carry no function.
  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:5]};

endmodule

// File: tb/tb_gus16.sv
// Directed bench for gus16: expected {uo_out, uio_out} pairs are queued when a
// command is driven and popped/compared once the result is visible.
module tb_gus16;
  import gus16_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  gus16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] uo, input logic [7:0] uio);
    exp_q.push_back({uo, uio});
  endtask

  task automatic check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      vectors++;
      assert ({uo_out, uio_out} === e) else begin
        miscompares++;
        $error("FAIL %s: uo_out/uio_out got %h/%h expected %h/%h",
               tag, uo_out, uio_out, e[15:8], e[7:0]);
      end
    end
  endtask

  // One strobe pulse: high for the execute edge, then low for one edge.
  task automatic cmd(input logic [3:0] code, input logic [7:0] d,
                     input logic [7:0] uo, input logic [7:0] uio, input string tag);
    push(uo, uio);
    ui_in  = d;
    uio_in = {3'b000, 1'b1, code};
    @(posedge clk); #1;
    uio_in[4] = 1'b0;
    @(posedge clk); #1;
    check(tag);
  endtask

  initial begin
    // Reset state
    #12;
    push(8'h00, 8'h00);
    check("reset_out");
    vectors++;
    assert (uio_oe === 8'hE0) else begin
      miscompares++;
      $error("FAIL reset_oe: got %h expected e0", uio_oe);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(8'h00, 8'h00);
    check("idle");

    // Load B, move to A, byte select
    cmd(OP_LDBL, 8'h34, 8'h00, 8'h00, "ldbl");
    cmd(OP_LDBH, 8'h12, 8'h00, 8'h00, "ldbh");
    cmd(OP_MOVA, 8'h00, 8'h34, 8'h00, "mova_1234");
    cmd(OP_SELH, 8'h00, 8'h12, 8'h00, "selh");
    cmd(OP_SELL, 8'h00, 8'h34, 8'h00, "sell");

    // A=FFFF, B=0001, ADD wraps; then DEC wraps back
    cmd(OP_LDBL, 8'hFF, 8'h34, 8'h00, "ldbl_ff");
    cmd(OP_LDBH, 8'hFF, 8'h34, 8'h00, "ldbh_ff");
    cmd(OP_MOVA, 8'h00, 8'hFF, 8'h40, "mova_ffff");
    cmd(OP_LDBL, 8'h01, 8'hFF, 8'h40, "ldbl_01");
    cmd(OP_LDBH, 8'h00, 8'hFF, 8'h40, "ldbh_00");
    cmd(OP_ADD,  8'h00, 8'h00, 8'hA0, "add_wrap");
    cmd(OP_DEC,  8'h00, 8'hFF, 8'h60, "dec_wrap");
    cmd(OP_CLR,  8'h00, 8'h00, 8'h00, "clr");

    // Strobe held high 5 cycles: single INC
    push(8'h01, 8'h00);
    uio_in = {3'b000, 1'b1, OP_INC};
    repeat (5) @(posedge clk);
    #1;
    uio_in[4] = 1'b0;
    @(posedge clk); #1;
    check("inc_held");

    // Deselected: strobe edge ignored
    ena = 1'b0;
    cmd(OP_INC, 8'h00, 8'h01, 8'h00, "ena_low");
    ena = 1'b1;

    // Shifts and XOR
    cmd(OP_LDBL, 8'h01, 8'h01, 8'h00, "ldbl_01b");
    cmd(OP_LDBH, 8'h80, 8'h01, 8'h00, "ldbh_80");
    cmd(OP_MOVA, 8'h00, 8'h01, 8'h40, "mova_8001");
    cmd(OP_SHL,  8'h00, 8'h02, 8'h20, "shl");
    cmd(OP_SHR,  8'h00, 8'h01, 8'h00, "shr");
    cmd(OP_LDBH, 8'h00, 8'h01, 8'h00, "ldbh_00b");
    cmd(OP_XOR,  8'h00, 8'h00, 8'h80, "xor_zero");

    // SUB borrow, AND, OR
    cmd(OP_SUB,  8'h00, 8'hFF, 8'h60, "sub_borrow");
    cmd(OP_SELH, 8'h00, 8'hFF, 8'h60, "selh_ffff");
    cmd(OP_AND,  8'h00, 8'h00, 8'h00, "and");
    cmd(OP_SELL, 8'h00, 8'h01, 8'h00, "sell_0001");
    cmd(OP_LDBH, 8'hF0, 8'h01, 8'h00, "ldbh_f0");
    cmd(OP_OR,   8'h00, 8'h01, 8'h40, "or");
    cmd(OP_SELH, 8'h00, 8'hF0, 8'h40, "selh_f001");

    // Opcode 0: MUL when enabled, otherwise NOP
    cmd(OP_SELL, 8'h00, 8'h01, 8'h40, "sell_f001");
    cmd(OP_LDBL, 8'hFF, 8'h01, 8'h40, "ldbl_ff2");
    cmd(OP_LDBH, 8'h00, 8'h01, 8'h40, "ldbh_00c");
    cmd(OP_MOVA, 8'h00, 8'hFF, 8'h00, "mova_00ff");
`ifdef GUS16_MUL_EN
    cmd(OP_NOP,  8'h00, 8'h01, 8'h40, "mul");
    cmd(OP_SELH, 8'h00, 8'hFE, 8'h40, "mul_hi");
`else
    cmd(OP_NOP,  8'h00, 8'hFF, 8'h00, "nop");
    cmd(OP_SELH, 8'h00, 8'h00, 8'h00, "nop_hi");
`endif

    // Asynchronous reset mid-sequence discards all state
    rst_n = 1'b0;
    #2;
    push(8'h00, 8'h00);
    check("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(OP_MOVA, 8'h00, 8'h00, 8'h80, "post_reset_b0");
    cmd(OP_INC,  8'h00, 8'h01, 8'h00, "post_reset_inc");

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
